// File: rtl/wb_dma_irq_pkg.sv
// ============================================================================
// Module   : wb_dma_irq_pkg
// Brief    : Register map, COAL field layout and coalescing FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wb_dma_irq_pkg;

  localparam logic [2:0] c_reg_pend_done = 3'd0;
  localparam logic [2:0] c_reg_pend_err  = 3'd1;
  localparam logic [2:0] c_reg_mask_a    = 3'd2;
  localparam logic [2:0] c_reg_mask_b    = 3'd3;
  localparam logic [2:0] c_reg_coal      = 3'd4;

  localparam int c_coal_thresh_lsb  = 0;
  localparam int c_coal_thresh_msb  = 3;
  localparam int c_coal_timeout_lsb = 16;
  localparam int c_coal_timeout_msb = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIRE  = 2'd2
  } coal_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_dma_irq_coal.sv
// ============================================================================
// Module   : wb_dma_irq_coal
// Brief    : Popcount of pending sources plus threshold/timeout coalescing FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_dma_irq_coal
  import wb_dma_irq_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i_src,
  input  logic [3:0]     i_thresh,
  input  logic [15:0]    i_timeout,
  output logic           o_fire
);

  coal_state_t r_state;
  coal_state_t w_state_nxt;
  logic [15:0] r_timer;
  logic [15:0] w_timer_nxt;
  logic [4:0]  w_cnt;
  logic [4:0]  w_thresh_eff;
  logic        w_any;
  logic        w_hit;
  logic        w_expire;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cnt = w_cnt + 5'(i_src[i]);
    end
  end

  assign w_any        = |i_src;
  assign w_thresh_eff = (i_thresh == 4'd0) ? 5'd1 : {1'b0, i_thresh};
  assign w_hit        = (w_cnt >= w_thresh_eff);
  // Expire on the edge where the down-count would land on 1.
  assign w_expire     = (i_timeout != 16'd0) && (r_timer != 16'd0) && (r_timer <= 16'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          if (w_hit) begin
            w_state_nxt = ST_FIRE;
          end else begin
            w_state_nxt = ST_ACCUM;
            w_timer_nxt = i_timeout;
          end
        end
      end
      ST_ACCUM: begin
        if (!w_any) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hit || w_expire) begin
          w_state_nxt = ST_FIRE;
        end else if (r_timer != 16'd0) begin
          w_timer_nxt = r_timer - 16'd1;
        end
      end
      ST_FIRE: begin
        if (!w_any) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign o_fire = (r_state == ST_FIRE);

endmodule

`default_nettype wire

// File: rtl/wb_dma_irq_ctrl.sv
// ============================================================================
// Module   : wb_dma_irq_ctrl
// Brief    : DMA interrupt controller: W1C pending registers, masks, coalescing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_dma_irq_ctrl
  import wb_dma_irq_pkg::*;
#(
  parameter int NCH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] ch_done,
  input  logic [NCH-1:0] ch_err,
  input  logic           reg_we,
  input  logic [2:0]     reg_addr,
  input  logic [31:0]    reg_wdata,
  output logic [31:0]    reg_rdata,
  output logic           inta,
  output logic           intb
);

  logic [NCH-1:0] r_pend_done;
  logic [NCH-1:0] r_pend_err;
  logic [NCH-1:0] r_mask_a;
  logic [NCH-1:0] r_mask_b;
  logic [3:0]     r_thresh;
  logic [15:0]    r_timeout;
  logic           r_intb;
  logic [NCH-1:0] w_w1c_done;
  logic [NCH-1:0] w_w1c_err;
  logic [NCH-1:0] w_src_a;
  logic           w_unused_wdata;

  assign w_w1c_done     = (reg_we && reg_addr == c_reg_pend_done) ? reg_wdata[NCH-1:0] : '0;
  assign w_w1c_err      = (reg_we && reg_addr == c_reg_pend_err)  ? reg_wdata[NCH-1:0] : '0;
  assign w_unused_wdata = ^reg_wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_done <= '0;
      r_pend_err  <= '0;
      r_mask_a    <= '0;
      r_mask_b    <= '0;
      r_thresh    <= '0;
      r_timeout   <= '0;
      r_intb      <= 1'b0;
    end else begin
      // New events are OR-ed in after the clear so a same-cycle event wins.
      r_pend_done <= (r_pend_done & ~w_w1c_done) | ch_done;
      r_pend_err  <= (r_pend_err  & ~w_w1c_err)  | ch_err;
      r_intb      <= |(r_pend_err & r_mask_b);
      if (reg_we) begin
        case (reg_addr)
          c_reg_mask_a: r_mask_a <= reg_wdata[NCH-1:0];
          c_reg_mask_b: r_mask_b <= reg_wdata[NCH-1:0];
          c_reg_coal: begin
            r_thresh  <= reg_wdata[c_coal_thresh_msb:c_coal_thresh_lsb];
            r_timeout <= reg_wdata[c_coal_timeout_msb:c_coal_timeout_lsb];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      c_reg_pend_done: reg_rdata[NCH-1:0] = r_pend_done;
      c_reg_pend_err:  reg_rdata[NCH-1:0] = r_pend_err;
      c_reg_mask_a:    reg_rdata[NCH-1:0] = r_mask_a;
      c_reg_mask_b:    reg_rdata[NCH-1:0] = r_mask_b;
      c_reg_coal: begin
        reg_rdata[c_coal_thresh_msb:c_coal_thresh_lsb]   = r_thresh;
        reg_rdata[c_coal_timeout_msb:c_coal_timeout_lsb] = r_timeout;
      end
      default: reg_rdata = '0;
    endcase
  end

  assign w_src_a = (r_pend_done | r_pend_err) & r_mask_a;

  wb_dma_irq_coal #(
    .NCH (NCH)
  ) u_coal (
    .clk       (clk_i),
    .rst       (rst_i),
    .i_src     (w_src_a),
    .i_thresh  (r_thresh),
    .i_timeout (r_timeout),
    .o_fire    (inta)
  );

  assign intb = r_intb;

endmodule

`default_nettype wire

// File: tb/tb_wb_dma_irq_ctrl.sv
// ============================================================================
// Module   : tb_wb_dma_irq_ctrl
// Brief    : Directed self-checking bench for wb_dma_irq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_dma_irq_ctrl;
  import wb_dma_irq_pkg::*;

  localparam int NCH = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NCH-1:0] ch_done;
  logic [NCH-1:0] ch_err;
  logic           reg_we;
  logic [2:0]     reg_addr;
  logic [31:0]    reg_wdata;
  logic [31:0]    reg_rdata;
  logic           inta;
  logic           intb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  wb_dma_irq_ctrl #(
    .NCH (NCH)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ch_done   (ch_done),
    .ch_err    (ch_err),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .inta      (inta),
    .intb      (intb)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; ch_done = '0; ch_err = '0;
    reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(); tick();
    check("rst_inta", 32'(inta), 32'd0);
    check("rst_intb", 32'(intb), 32'd0);
    rd("rst_pend_done", c_reg_pend_done, 32'd0);
    rd("rst_coal", c_reg_coal, 32'd0);
    rst_i = 1'b0;
    tick();

    // register map, field truncation and unmapped addresses
    wr(c_reg_mask_a, 32'hFFFF_FFFF);
    rd("mask_a_trunc", c_reg_mask_a, 32'h0000_00FF);
    wr(c_reg_coal, 32'hFFFF_FFFF);
    rd("coal_fields", c_reg_coal, 32'hFFFF_000F);
    wr(3'd5, 32'hFFFF_FFFF);
    rd("addr5_zero", 3'd5, 32'd0);
    rd("addr7_zero", 3'd7, 32'd0);
    rd("addr5_no_side", c_reg_mask_b, 32'd0);

    // single channel, THRESH=1
    wr(c_reg_mask_a, 32'h01);
    wr(c_reg_coal, 32'h0000_0001);
    ch_done = 8'h01; tick(); ch_done = '0;
    rd("t1_pend", c_reg_pend_done, 32'h01);
    check("t1_inta_e", 32'(inta), 32'd0);
    tick();
    check("t1_inta_e1", 32'(inta), 32'd1);
    wr(c_reg_pend_done, 32'h01);
    rd("t1_pend_clr", c_reg_pend_done, 32'h00);
    check("t1_inta_w", 32'(inta), 32'd1);
    tick();
    check("t1_inta_w1", 32'(inta), 32'd0);

    // masked channel and W1C with zero data
    ch_done = 8'h02; tick(); ch_done = '0;
    tick(); tick();
    check("mask_inta", 32'(inta), 32'd0);
    wr(c_reg_pend_done, 32'h00);
    rd("w1c_zero", c_reg_pend_done, 32'h02);
    wr(c_reg_pend_done, 32'h02);
    rd("w1c_one", c_reg_pend_done, 32'h00);

    // THRESH=3, timer disabled
    wr(c_reg_coal, 32'h0000_0003);
    wr(c_reg_mask_a, 32'hFF);
    ch_done = 8'h02; tick(); ch_done = '0;
    repeat (9) tick();
    check("t3_after1", 32'(inta), 32'd0);
    ch_done = 8'h04; tick(); ch_done = '0;
    repeat (9) tick();
    check("t3_after2", 32'(inta), 32'd0);
    ch_done = 8'h08; tick(); ch_done = '0;
    check("t3_e", 32'(inta), 32'd0);
    tick();
    check("t3_fire", 32'(inta), 32'd1);
    wr(c_reg_pend_done, 32'h0E);
    tick();
    check("t3_clear", 32'(inta), 32'd0);

    // THRESH=4, TIMEOUT=5: FIRE four cycles after entering ACCUM
    wr(c_reg_coal, 32'h0005_0004);
    ch_done = 8'h01; tick(); ch_done = '0;
    tick();
    repeat (3) tick();
    check("to_e4", 32'(inta), 32'd0);
    tick();
    check("to_e5", 32'(inta), 32'd1);
    wr(c_reg_pend_done, 32'h01);
    tick();
    check("to_clear", 32'(inta), 32'd0);

    // THRESH=0 behaves as 1
    wr(c_reg_coal, 32'h0000_0000);
    ch_done = 8'h10; tick(); ch_done = '0;
    tick();
    check("th0_fire", 32'(inta), 32'd1);
    wr(c_reg_pend_done, 32'h10);
    tick();
    check("th0_clear", 32'(inta), 32'd0);

    // error event and W1C on the same bit in the same cycle
    wr(c_reg_mask_b, 32'h04);
    ch_err = 8'h04; reg_we = 1'b1; reg_addr = c_reg_pend_err; reg_wdata = 32'h04;
    tick();
    ch_err = '0; reg_we = 1'b0;
    rd("race_pend", c_reg_pend_err, 32'h04);
    check("race_intb_e", 32'(intb), 32'd0);
    tick();
    check("race_intb_e1", 32'(intb), 32'd1);
    check("race_inta_e1", 32'(inta), 32'd1);
    wr(c_reg_pend_err, 32'h04);
    rd("err_clr", c_reg_pend_err, 32'h00);
    check("err_intb_w", 32'(intb), 32'd1);
    tick();
    check("err_intb_w1", 32'(intb), 32'd0);
    check("err_inta_w1", 32'(inta), 32'd0);

    // error on a channel outside MASK_B
    ch_err = 8'h01; tick(); ch_err = '0;
    tick();
    check("errm_intb", 32'(intb), 32'd0);
    check("errm_inta", 32'(inta), 32'd1);
    wr(c_reg_pend_err, 32'h01);
    tick();

    // asynchronous reset while both interrupts are active
    ch_err = 8'h04; tick(); ch_err = '0;
    tick();
    check("pre_rst_inta", 32'(inta), 32'd1);
    check("pre_rst_intb", 32'(intb), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_inta", 32'(inta), 32'd0);
    check("arst_intb", 32'(intb), 32'd0);
    rd("arst_pend_err", c_reg_pend_err, 32'd0);
    rd("arst_mask_a", c_reg_mask_a, 32'd0);
    rd("arst_mask_b", c_reg_mask_b, 32'd0);
    ch_done = 8'hFF;
    tick();
    ch_done = '0;
    rst_i = 1'b0;
    tick();
    rd("rst_ignore_ev", c_reg_pend_done, 32'd0);
    check("post_rst_inta", 32'(inta), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
